mod_loader: RTL
===============

# mod_loader

Hardware program loader: the initiator counterpart of the memory modules' data port. It accepts a byte stream from the UART receiver, assembles big-endian 32-bit words, writes them sequentially into RAM through the standard module interface (de/daddr/drw/din), and reads each word back to verify it. It sits between the UART RX path and the RAM data port, behind the bus arbiter, and replaces the software bootloader's copy loop.

## Interface
- BASE, 32'h1000_0000: RAM byte address of word 0.
- MAX_WORDS, 8192: largest accepted payload length in words.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- rx_valid  in  1  rx_data holds a received byte.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready).
- de  out  1  memory data-port enable.
- drw  out  1  1 = write, 0 = read; meaningful only when de = 1.
- daddr  out  32  word-aligned byte address (bits [1:0] = 0).
- dout  out  32  write data, driven to memory din.
- mem_rdata  in  32  memory dout; valid the cycle after a read (de=1, drw=0).
- busy  out  1  load in progress.
- done  out  1  load completed, checksum good; held until next start or rst.
- err  out  1  load failed; held until next start or rst.
- words  out  32  words written so far in this load.

## Operation
- Stream format: LEN (4 bytes, MSB first), then LEN data words (MSB first each), then CSUM (4 bytes) = sum of data words mod 2^32.
- States: IDLE, GET_LEN, GET_DATA, WRITE, READ, CMP, GET_CSUM, DONE, ERR.
- IDLE/DONE/ERR --start--> GET_LEN; clears words, running sum, byte counter, done, err.
- GET_LEN: collect 4 bytes. If LEN = 0 or LEN > MAX_WORDS -> ERR; else -> GET_DATA.
- GET_DATA: collect 4 bytes -> WRITE.
- WRITE: de=1, drw=1, daddr = BASE + 4*words, dout = word; -> READ.
- READ: de=1, drw=0, same daddr; -> CMP.
- CMP: de=0. mem_rdata != word -> ERR. Else increment words, add word to sum; -> GET_CSUM if words (new value) = LEN, else GET_DATA.
- GET_CSUM: collect 4 bytes; equal to sum -> DONE, else ERR.
- rx_ready = 1 only in GET_LEN, GET_DATA and GET_CSUM; bytes are never dropped silently, the UART FIFO holds them.
- start outside IDLE/DONE/ERR is ignored. Extra bytes after CSUM are not consumed (rx_ready = 0).
- Address arithmetic: 32-bit, wrap-around not checked; MAX_WORDS bounds the range.

## Timing
- All outputs are registered. Reset values: rx_ready=0, de=0, drw=0, daddr=0, dout=0, busy=0, done=0, err=0, words=0; state IDLE.
- rst sampled high mid-load: on that edge all outputs go to reset values and no further memory access occurs; memory contents already written are left as is.
- start seen at edge N: busy=1 and rx_ready=1 from cycle N+1.
- 4th byte of a data word accepted at edge N: WRITE in cycle N+1, READ in N+2, compare in N+3, rx_ready=1 again in N+4 (if more bytes expected). Minimum 7 cycles per word at full rx rate.
- done/err rise in the cycle after the deciding edge; busy falls in the same cycle.

## Structure
- Package loader_pkg: state enum, LEN/CSUM byte count (4), default BASE and MAX_WORDS.
- Sub-module loader_word_asm: 2-bit byte counter + 32-bit shift register; outputs word and word_valid on 4th byte, cleared by the FSM. Shared by GET_LEN, GET_DATA, GET_CSUM.

## Test plan
- LEN=2, words 0xDEADBEEF, 0x01020304, CSUM=0xDFAFC1F3 -> writes to 0x10000000 and 0x10000004 with those values, each followed by a read of the same address; done=1, words=2.
- LEN=0 -> err=1 one cycle after 4th LEN byte; no de pulse at all.
- LEN=MAX_WORDS+1 -> err=1, no memory access; then start again with valid stream -> done=1.
- Memory model corrupts readback of word 1 (bit 0 flipped) -> err=1 in cycle after CMP, words=1, no further writes, rx_ready=0.
- Valid LEN=1 word 0x00000005, CSUM=0x00000006 -> err=1, words=1, done=0.
- rst asserted in cycle after WRITE of word 3 of 5 -> next cycle de=0, busy=0, words=0; rx_valid held high gets rx_ready=0 until start.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// loader_pkg : shared types and defaults for the UART-to-RAM program loader
// rev 1.0
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_LEN  = 4'd1,
    S_GET_DATA = 4'd2,
    S_WRITE    = 4'd3,
    S_READ     = 4'd4,
    S_CMP      = 4'd5,
    S_GET_CSUM = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } state_t;

  localparam int unsigned HDR_BYTES     = 4;
  localparam logic [1:0]  LAST_BYTE_IDX = 2'(HDR_BYTES - 1);
  localparam logic [31:0] DEF_BASE      = 32'h1000_0000;
  localparam int unsigned DEF_MAX_WORDS = 8192;

endpackage
`default_nettype wire

// File: rtl/mod_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_loader_if : control, UART byte stream and RAM data port of the loader
// rev 1.0
// ---------------------------------------------------------------------------
interface mod_loader_if;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        de;
  logic        drw;
  logic [31:0] daddr;
  logic [31:0] dout;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] words;

  modport master (
    input  start, rx_valid, rx_data, mem_rdata,
    output rx_ready, de, drw, daddr, dout, busy, done, err, words
  );

  modport slave (
    output start, rx_valid, rx_data, mem_rdata,
    input  rx_ready, de, drw, daddr, dout, busy, done, err, words
  );
endinterface
`default_nettype wire

// File: rtl/loader_word_asm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// loader_word_asm : packs four MSB-first bytes into a 32-bit word
// rev 1.0
// ---------------------------------------------------------------------------
module loader_word_asm
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;
  logic [31:0] w_word;

  // Word is presented in the same cycle as its last byte so the FSM can act on that edge
  assign w_word       = {r_shift, i_byte};
  assign o_word       = w_word;
  assign o_word_valid = i_byte_valid && (r_cnt == LAST_BYTE_IDX);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= w_word[23:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_loader : loads a length/data/checksum byte stream into RAM, verifying
//              every word by readback. rev 1.0
// ---------------------------------------------------------------------------
module mod_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE      = DEF_BASE,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  mod_loader_if.master bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_xfer;
  logic        w_clr;
  logic        w_asm_valid;
  logic [31:0] w_asm_word;
  logic [31:0] w_words_inc;

  logic [31:0] r_len;
  logic [31:0] r_word;
  logic [31:0] r_sum;
  logic [31:0] r_words;
  logic        r_rx_ready;
  logic        r_de;
  logic        r_drw;
  logic [31:0] r_daddr;
  logic [31:0] r_dout;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  assign w_xfer      = bus.rx_valid & r_rx_ready;
  assign w_words_inc = r_words + 32'd1;

  loader_word_asm u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_byte_valid (w_xfer),
    .i_byte       (bus.rx_data),
    .o_word       (w_asm_word),
    .o_word_valid (w_asm_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          w_state_nxt = S_GET_LEN;
          w_clr       = 1'b1;
        end
      end
      S_GET_LEN: begin
        if (w_asm_valid) begin
          if (w_asm_word == 32'd0 || w_asm_word > 32'(MAX_WORDS))
            w_state_nxt = S_ERR;
          else
            w_state_nxt = S_GET_DATA;
        end
      end
      S_GET_DATA: begin
        if (w_asm_valid) w_state_nxt = S_WRITE;
      end
      S_WRITE: w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_CMP;
      S_CMP: begin
        if (bus.mem_rdata != r_word)
          w_state_nxt = S_ERR;
        else if (w_words_inc == r_len)
          w_state_nxt = S_GET_CSUM;
        else
          w_state_nxt = S_GET_DATA;
      end
      S_GET_CSUM: begin
        if (w_asm_valid) w_state_nxt = (w_asm_word == r_sum) ? S_DONE : S_ERR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ready <= 1'b0;
      r_de       <= 1'b0;
      r_drw      <= 1'b0;
      r_daddr    <= 32'd0;
      r_dout     <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= 32'd0;
      r_sum      <= 32'd0;
      r_len      <= 32'd0;
      r_word     <= 32'd0;
    end else begin
      r_rx_ready <= (w_state_nxt inside {S_GET_LEN, S_GET_DATA, S_GET_CSUM});
      r_de       <= (w_state_nxt inside {S_WRITE, S_READ});
      r_drw      <= (w_state_nxt == S_WRITE);
      r_busy     <= !(w_state_nxt inside {S_IDLE, S_DONE, S_ERR});
      r_done     <= (w_state_nxt == S_DONE);
      r_err      <= (w_state_nxt == S_ERR);

      if (w_clr) begin
        r_words <= 32'd0;
        r_sum   <= 32'd0;
      end
      if (r_state == S_GET_LEN && w_asm_valid)
        r_len <= w_asm_word;
      if (r_state == S_GET_DATA && w_asm_valid) begin
        r_word  <= w_asm_word;
        r_dout  <= w_asm_word;
        r_daddr <= BASE + {r_words[29:0], 2'b00};
      end
      if (r_state == S_CMP && bus.mem_rdata == r_word) begin
        r_words <= w_words_inc;
        r_sum   <= r_sum + r_word;
      end
    end
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.de       = r_de;
  assign bus.drw      = r_drw;
  assign bus.daddr    = r_daddr;
  assign bus.dout     = r_dout;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.words    = r_words;

endmodule
`default_nettype wire
